rtc_bus_responder: RTL and testbench
====================================

Name: rtc_bus_responder

Overview:
- Synthesizable responder for the RTC-side end of the multiplexed address/data strobe bus (AD, RD, CS, WR, 8-bit AD bus).
- Decodes address-phase and data-phase cycles from the bus master and holds a local register file.
- Drives read data back onto the bus with an output enable.
- Used as an on-chip RTC stand-in and as the loopback target for bring-up of the bus sequencer.

Parameters:
- NUM_REGS, 16, register-file depth; legal addresses 0..NUM_REGS-1.
- RESP_DFLT, 8'hFF, read value returned for addresses >= NUM_REGS.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- AD  input  1  address/data select; 0 = address phase, 1 = data phase
- RD  input  1  read strobe, active-low
- CS  input  1  chip select, active-low
- WR  input  1  write strobe, active-low
- ADin  input  8  bus value driven by master
- ADout  output  8  read data toward master
- data_oe  output  1  high while responder drives ADout
- wr_strobe  output  1  one-cycle pulse on a committed data write
- wr_addr  output  8  address of committed write, valid with wr_strobe
- wr_data  output  8  data of committed write, valid with wr_strobe
- host_addr  input  8  local combinational read port address
- host_data  output  8  regfile[host_addr], or RESP_DFLT if out of range
- cur_addr  output  8  current latched address
- proto_err  output  1  one-cycle pulse on protocol violation

Behaviour:
- Reset (async): state=IDLE; cur_addr=0; all registers=0; ADout=0; data_oe=0; wr_strobe=0; wr_addr=0; wr_data=0; proto_err=0; synchronizers preset to bus-idle (AD=1, RD=1, CS=1, WR=1, ADin=0).
- All five bus inputs pass through 2-flop synchronizers; the FSM sees only the synchronized copies (_s).
- States: IDLE, ADDR_WR, DATA_WR, DATA_RD.
- IDLE transitions:
  - CS_s=0, WR_s=0, RD_s=1, AD_s=0 -> ADDR_WR
  - CS_s=0, WR_s=0, RD_s=1, AD_s=1 -> DATA_WR
  - CS_s=0, RD_s=0, WR_s=1, AD_s=1 -> DATA_RD
  - CS_s=0, RD_s=0, WR_s=0 -> proto_err pulse; stay IDLE
  - CS_s=0, RD_s=0, AD_s=0 (read in address phase) -> proto_err pulse; stay IDLE
  - otherwise -> stay IDLE
- ADDR_WR and DATA_WR:
  - Shadow register captures ADin_s every cycle while WR_s=0.
  - On WR_s=1 with CS_s=0: commit, then -> IDLE.
  - ADDR_WR commit: cur_addr <= shadow.
  - DATA_WR commit: if cur_addr < NUM_REGS, regfile[cur_addr] <= shadow and wr_strobe pulses with wr_addr/wr_data; else the write is dropped and no strobe is issued.
  - CS_s=1 before WR_s=1: abort, no commit, -> IDLE.
  - RD_s=0 during either state: proto_err pulse, abort, -> IDLE.
- DATA_RD:
  - data_oe=1; ADout = regfile[cur_addr], or RESP_DFLT if out of range; both registered.
  - RD_s=1 or CS_s=1 -> IDLE; data_oe=0 from the next edge.
  - WR_s=0 during DATA_RD: proto_err pulse, -> IDLE.
- Latency:
  - data_oe rises on the 4th rising clk edge after RD pin falls (2 sync + FSM + output register).
  - data_oe falls 4 edges after RD pin rises.
  - wr_strobe asserts 4 edges after WR pin rises.
- wr_strobe and proto_err are single-cycle pulses, never stretched.
- Regfile write and host read of the same address in the same cycle: host_data shows the old value; the new value appears the next cycle.
- Reset mid-transaction: immediate return to IDLE, outputs to reset values, no partial commit.

Optional Feature:
- Macro: RTC_RESP_AUTOINC_EN.
- Defined: after each committed data write or each completed DATA_RD exit, cur_addr <= (cur_addr+1) mod NUM_REGS. An out-of-range cur_addr goes to 0.
- Undefined: cur_addr changes only on ADDR_WR commit.

Test Plan:
- Reset, then idle bus for 20 cycles -> data_oe=0, cur_addr=0, no pulses.
- Address cycle 8'h05, then data write 8'h3C -> cur_addr=5; one wr_strobe with wr_addr=5, wr_data=8'h3C; host_addr=5 returns 8'h3C.
- Address 8'h05, then RD low for 10 cycles -> data_oe high from 4th edge for 7 cycles; ADout=8'h3C; data_oe low 4 edges after RD rises.
- Address 8'h20 (>= NUM_REGS), write 8'h11, then read -> no wr_strobe; ADout=8'hFF.
- RD and WR both low with CS low; also CS high mid-write -> one proto_err pulse for the first; no commit for the second; FSM back in IDLE.
- With RTC_RESP_AUTOINC_EN: address 8'h0F, write 8'hAA, then write 8'hBB -> regfile[15]=8'hAA, regfile[0]=8'hBB, cur_addr=1.

Source files
------------

// File: rtl/rtc_bus_responder_if.sv
// Multiplexed address/data strobe bus between the bus sequencer (master)
// and the RTC-side responder (slave). Strobes RD/CS/WR are active-low;
// AD selects address phase (0) or data phase (1).
interface rtc_bus_responder_if;
    logic       AD;
    logic       RD;
    logic       CS;
    logic       WR;
    logic [7:0] ADin;
    logic [7:0] ADout;
    logic       data_oe;

    modport master (
        output AD, RD, CS, WR, ADin,
        input  ADout, data_oe
    );

    modport slave (
        input  AD, RD, CS, WR, ADin,
        output ADout, data_oe
    );
endinterface

// File: rtl/rtc_bus_responder.sv
// RTC-side responder for the multiplexed AD/RD/CS/WR strobe bus.
// Decodes address and data phases, holds a small register file, returns
// read data with an output enable and exposes a combinational host port.
// Optional feature macro: RTC_RESP_AUTOINC_EN -- when defined, cur_addr
// advances (mod NUM_REGS) after each committed data write and each
// completed read; an out-of-range cur_addr wraps to 0.
//
// state   | meaning
// IDLE    | bus idle, waiting for a legal strobe combination
// ADDR_WR | address-phase write open, shadow follows ADin
// DATA_WR | data-phase write open, shadow follows ADin
// DATA_RD | read open, ADout/data_oe driven toward the master
module rtc_bus_responder #(
    parameter int         NUM_REGS  = 16,
    parameter logic [7:0] RESP_DFLT = 8'hFF
) (
    input  logic               clk,
    input  logic               reset,
    rtc_bus_responder_if.slave bus,
    output logic               wr_strobe,
    output logic [7:0]         wr_addr,
    output logic [7:0]         wr_data,
    input  logic [7:0]         host_addr,
    output logic [7:0]         host_data,
    output logic [7:0]         cur_addr,
    output logic               proto_err
);

    localparam int         AW     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [8:0] NREGS9 = 9'(NUM_REGS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ADDR_WR = 2'd1,
        DATA_WR = 2'd2,
        DATA_RD = 2'd3
    } state_t;

    state_t state;
    state_t nxt_state;

    logic [1:0] ad_sy;
    logic [1:0] rd_sy;
    logic [1:0] cs_sy;
    logic [1:0] wr_sy;
    logic [7:0] adin_sy0;
    logic [7:0] adin_sy1;

    logic       ad_s;
    logic       rd_s;
    logic       cs_s;
    logic       wr_s;
    logic [7:0] adin_s;

    logic [7:0] regfile [NUM_REGS];
    logic [7:0] shadow;
    logic [7:0] cmt_val_q;

    logic       addr_cmt;
    logic       data_cmt;
    logic       perr;
    logic       illegal;
    logic       illegal_q;
    logic       addr_cmt_q;
    logic       data_cmt_q;

    logic       cur_in_range;
    logic       host_in_range;
    logic [7:0] rd_val;

`ifdef RTC_RESP_AUTOINC_EN
    logic       rd_done;
    logic       rd_done_q;
    logic [7:0] inc_addr;
`endif

    assign ad_s   = ad_sy[1];
    assign rd_s   = rd_sy[1];
    assign cs_s   = cs_sy[1];
    assign wr_s   = wr_sy[1];
    assign adin_s = adin_sy1;

    // Two-flop synchronizers, preset to the idle bus so reset never looks like a strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ad_sy    <= 2'b11;
            rd_sy    <= 2'b11;
            cs_sy    <= 2'b11;
            wr_sy    <= 2'b11;
            adin_sy0 <= 8'h00;
            adin_sy1 <= 8'h00;
        end else begin
            ad_sy    <= {ad_sy[0], bus.AD};
            rd_sy    <= {rd_sy[0], bus.RD};
            cs_sy    <= {cs_sy[0], bus.CS};
            wr_sy    <= {wr_sy[0], bus.WR};
            adin_sy0 <= bus.ADin;
            adin_sy1 <= adin_sy0;
        end
    end

    // Address range decode and combinational read values.
    always_comb begin
        cur_in_range  = ({1'b0, cur_addr} < NREGS9);
        host_in_range = ({1'b0, host_addr} < NREGS9);
        rd_val        = cur_in_range ? regfile[cur_addr[AW-1:0]] : RESP_DFLT;
        host_data     = host_in_range ? regfile[host_addr[AW-1:0]] : RESP_DFLT;
        // Read with write, or read in the address phase, while selected.
        illegal       = !cs_s && !rd_s && (!wr_s || !ad_s);
    end

`ifdef RTC_RESP_AUTOINC_EN
    // Next sequential address, wrapping at NUM_REGS; out-of-range restarts at 0.
    always_comb begin
        inc_addr = cur_addr + 8'd1;
        if (!cur_in_range || ({1'b0, cur_addr} == (NREGS9 - 9'd1))) begin
            inc_addr = 8'h00;
        end
    end
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nxt_state;
        end
    end

    // Next-state decode and commit/error events.
    always_comb begin
        nxt_state = state;
        addr_cmt  = 1'b0;
        data_cmt  = 1'b0;
        perr      = 1'b0;
`ifdef RTC_RESP_AUTOINC_EN
        rd_done   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (illegal) begin
                    // Only the onset of an illegal combination is reported,
                    // so a held violation yields a single pulse.
                    perr = !illegal_q;
                end else if (!cs_s && !wr_s && rd_s) begin
                    nxt_state = ad_s ? DATA_WR : ADDR_WR;
                end else if (!cs_s && !rd_s && wr_s && ad_s) begin
                    nxt_state = DATA_RD;
                end
            end
            ADDR_WR, DATA_WR: begin
                if (!rd_s) begin
                    perr      = 1'b1;
                    nxt_state = IDLE;
                end else if (cs_s) begin
                    nxt_state = IDLE;
                end else if (wr_s) begin
                    nxt_state = IDLE;
                    if (state == ADDR_WR) begin
                        addr_cmt = 1'b1;
                    end else begin
                        data_cmt = 1'b1;
                    end
                end
            end
            DATA_RD: begin
                if (!wr_s) begin
                    perr      = 1'b1;
                    nxt_state = IDLE;
                end else if (rd_s || cs_s) begin
                    nxt_state = IDLE;
`ifdef RTC_RESP_AUTOINC_EN
                    rd_done   = 1'b1;
`endif
                end
            end
            default: begin
                nxt_state = IDLE;
            end
        endcase
    end

    // Shadow capture and commit pipeline stage; proto_err leaves from here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow     <= 8'h00;
            cmt_val_q  <= 8'h00;
            addr_cmt_q <= 1'b0;
            data_cmt_q <= 1'b0;
            illegal_q  <= 1'b0;
            proto_err  <= 1'b0;
`ifdef RTC_RESP_AUTOINC_EN
            rd_done_q  <= 1'b0;
`endif
        end else begin
            if (!wr_s) begin
                shadow <= adin_s;
            end
            cmt_val_q  <= shadow;
            addr_cmt_q <= addr_cmt;
            data_cmt_q <= data_cmt;
            illegal_q  <= illegal;
            proto_err  <= perr;
`ifdef RTC_RESP_AUTOINC_EN
            rd_done_q  <= rd_done;
`endif
        end
    end

    // Apply commits: address latch, register write and the write strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_addr  <= 8'h00;
            wr_strobe <= 1'b0;
            wr_addr   <= 8'h00;
            wr_data   <= 8'h00;
            for (int i = 0; i < NUM_REGS; i++) begin
                regfile[i] <= 8'h00;
            end
        end else begin
            wr_strobe <= 1'b0;
            if (addr_cmt_q) begin
                cur_addr <= cmt_val_q;
            end
`ifdef RTC_RESP_AUTOINC_EN
            else if (data_cmt_q || rd_done_q) begin
                cur_addr <= inc_addr;
            end
`endif
            if (data_cmt_q && cur_in_range) begin
                regfile[cur_addr[AW-1:0]] <= cmt_val_q;
                wr_strobe                 <= 1'b1;
                wr_addr                   <= cur_addr;
                wr_data                   <= cmt_val_q;
            end
        end
    end

    // Registered read drive toward the master.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.data_oe <= 1'b0;
            bus.ADout   <= 8'h00;
        end else begin
            bus.data_oe <= (state == DATA_RD);
            bus.ADout   <= (state == DATA_RD) ? rd_val : 8'h00;
        end
    end

endmodule

// File: tb/tb_rtc_bus_responder.sv
// Self-checking bench for rtc_bus_responder: directed scenarios plus a
// randomized transaction run checked against a transaction-level model.
module tb_rtc_bus_responder;

    localparam int NREGS = 16;

    logic       clk;
    logic       reset;
    logic       wr_strobe;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] host_addr;
    logic [7:0] host_data;
    logic [7:0] cur_addr;
    logic       proto_err;

    rtc_bus_responder_if bif ();

    rtc_bus_responder #(.NUM_REGS(NREGS), .RESP_DFLT(8'hFF)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bif),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .host_addr (host_addr),
        .host_data (host_data),
        .cur_addr  (cur_addr),
        .proto_err (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

`ifdef RTC_RESP_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    // Transaction-level model of the register file and current address.
    logic [7:0] ref_mem [NREGS];
    logic [7:0] ref_cur;

    // Observed write strobes and protocol error pulses.
    logic [7:0] sq_addr [$];
    logic [7:0] sq_data [$];
    int         perr_cnt = 0;

    always @(negedge clk) begin
        if (wr_strobe === 1'b1) begin
            sq_addr.push_back(wr_addr);
            sq_data.push_back(wr_data);
        end
        if (proto_err === 1'b1) perr_cnt++;
    end

    task automatic m_reset();
        for (int i = 0; i < NREGS; i++) ref_mem[i] = 8'h00;
        ref_cur = 8'h00;
    endtask

    function automatic logic [7:0] m_host(input logic [7:0] a);
        return (a < NREGS) ? ref_mem[a] : 8'hFF;
    endfunction

    function automatic logic [7:0] m_advance(input logic [7:0] a);
        if (a < NREGS) return 8'((int'(a) + 1) % NREGS);
        return 8'h00;
    endfunction

    task automatic m_addr(input logic [7:0] a);
        ref_cur = a;
    endtask

    // Returns 1 when the model expects a write strobe.
    task automatic m_write(input logic [7:0] d, output bit strobe);
        strobe = (ref_cur < NREGS);
        if (strobe) ref_mem[ref_cur] = d;
        if (AUTOINC) ref_cur = m_advance(ref_cur);
    endtask

    task automatic m_read(output logic [7:0] v);
        v = m_host(ref_cur);
        if (AUTOINC) ref_cur = m_advance(ref_cur);
    endtask

    task automatic bus_idle();
        bif.CS   = 1'b1;
        bif.AD   = 1'b1;
        bif.RD   = 1'b1;
        bif.WR   = 1'b1;
        bif.ADin = 8'h00;
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One complete write cycle; returns after the commit pipeline has drained.
    task automatic bus_write(input logic ad, input logic [7:0] val);
        @(negedge clk);
        bif.CS = 1'b0; bif.AD = ad; bif.WR = 1'b0; bif.ADin = val;
        ticks(3);
        bif.WR = 1'b1;
        ticks(2);
        bif.CS = 1'b0;
        bif.CS = 1'b1; bif.AD = 1'b1; bif.ADin = 8'h00;
        ticks(4);
    endtask

    // Read with RD held low for len clock edges; reports data_oe timing
    // relative to the RD falling point (edge 1 is the first edge after it).
    task automatic bus_read(input int len, output int first, output int fall,
                            output int hi, output int hi_win,
                            output logic [7:0] dout, output int varied);
        logic prev;
        first = 0; fall = 0; hi = 0; hi_win = 0; dout = 8'h00; varied = 0;
        prev = 1'b0;
        @(negedge clk);
        bif.CS = 1'b0; bif.AD = 1'b1; bif.RD = 1'b0;
        for (int e = 1; e <= len + 8; e++) begin
            @(posedge clk); #1;
            if (bif.data_oe === 1'b1) begin
                if (hi == 0) begin
                    first = e;
                    dout  = bif.ADout;
                end else if (bif.ADout !== dout) begin
                    varied++;
                end
                hi++;
                if (e <= len) hi_win++;
            end else if (prev && fall == 0) begin
                fall = e;
            end
            prev = bif.data_oe;
            if (e == len) begin @(negedge clk); bif.RD = 1'b1; end
            if (e == len + 2) begin @(negedge clk); bif.CS = 1'b1; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus_idle();
        host_addr = 8'h00;
        ticks(3);
        checks++; if (bif.data_oe !== 1'b0) begin errors++; $display("FAIL rst_data_oe: got %b want 0", bif.data_oe); end
        checks++; if (bif.ADout !== 8'h00) begin errors++; $display("FAIL rst_adout: got %h want 00", bif.ADout); end
        checks++; if (wr_strobe !== 1'b0) begin errors++; $display("FAIL rst_wr_strobe: got %b want 0", wr_strobe); end
        checks++; if (wr_addr !== 8'h00) begin errors++; $display("FAIL rst_wr_addr: got %h want 00", wr_addr); end
        checks++; if (wr_data !== 8'h00) begin errors++; $display("FAIL rst_wr_data: got %h want 00", wr_data); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL rst_proto_err: got %b want 0", proto_err); end
        checks++; if (cur_addr !== 8'h00) begin errors++; $display("FAIL rst_cur_addr: got %h want 00", cur_addr); end
        checks++; if (host_data !== 8'h00) begin errors++; $display("FAIL rst_host_data: got %h want 00", host_data); end
        reset = 1'b0;
        m_reset();
        sq_addr.delete(); sq_data.delete();
        perr_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++; if (bif.data_oe !== 1'b0) begin errors++; $display("FAIL idle_data_oe c%0d: got %b want 0", c, bif.data_oe); end
            checks++; if (cur_addr !== 8'h00) begin errors++; $display("FAIL idle_cur_addr c%0d: got %h want 00", c, cur_addr); end
        end
        checks++; if (sq_addr.size() != 0) begin errors++; $display("FAIL idle_strobes: got %0d want 0", sq_addr.size()); end
        checks++; if (perr_cnt != 0) begin errors++; $display("FAIL idle_proto_err: got %0d want 0", perr_cnt); end
    endtask

    task automatic test_write_basic();
        logic [7:0] old_v, hb, ha;
        int st_edge, st_cnt;
        bit exp_st;
        bus_write(1'b0, 8'h05);
        m_addr(8'h05);
        checks++; if (cur_addr !== ref_cur) begin errors++; $display("FAIL wr_cur_addr_after_addr: got %h want %h", cur_addr, ref_cur); end
        host_addr = 8'h05;
        old_v = m_host(8'h05);
        sq_addr.delete(); sq_data.delete();
        st_edge = 0; st_cnt = 0; hb = 8'h00; ha = 8'h00;
        @(negedge clk);
        bif.CS = 1'b0; bif.AD = 1'b1; bif.WR = 1'b0; bif.ADin = 8'h3C;
        ticks(3);
        bif.WR = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            @(posedge clk); #1;
            if (wr_strobe === 1'b1) begin
                if (st_edge == 0) st_edge = e;
                st_cnt++;
            end
            if (e == 3) hb = host_data;
            if (e == 4) ha = host_data;
            if (e == 2) begin bif.CS = 1'b1; bif.AD = 1'b1; bif.ADin = 8'h00; end
        end
        ticks(3);
        m_write(8'h3C, exp_st);
        checks++; if (st_edge != 4) begin errors++; $display("FAIL wr_strobe_latency: got edge %0d want 4", st_edge); end
        checks++; if (st_cnt != 1) begin errors++; $display("FAIL wr_strobe_width: got %0d want 1", st_cnt); end
        checks++; if (sq_addr.size() != 1) begin errors++; $display("FAIL wr_strobe_count: got %0d want 1", sq_addr.size()); end
        checks++; if (sq_addr[0] !== 8'h05) begin errors++; $display("FAIL wr_addr: got %h want 05", sq_addr[0]); end
        checks++; if (sq_data[0] !== 8'h3C) begin errors++; $display("FAIL wr_data: got %h want 3c", sq_data[0]); end
        checks++; if (hb !== old_v) begin errors++; $display("FAIL host_before_write: got %h want %h", hb, old_v); end
        checks++; if (ha !== 8'h3C) begin errors++; $display("FAIL host_after_write: got %h want 3c", ha); end
        checks++; if (cur_addr !== ref_cur) begin errors++; $display("FAIL wr_cur_addr: got %h want %h", cur_addr, ref_cur); end
        checks++; if (host_data !== m_host(8'h05)) begin errors++; $display("FAIL host_5: got %h want %h", host_data, m_host(8'h05)); end
    endtask

    task automatic test_read_latency();
        int first, fall, hi, hi_win, varied;
        logic [7:0] dout, exp_v;
        bus_write(1'b0, 8'h05);
        m_addr(8'h05);
        bus_read(10, first, fall, hi, hi_win, dout, varied);
        m_read(exp_v);
        checks++; if (first != 4) begin errors++; $display("FAIL rd_oe_rise: got edge %0d want 4", first); end
        checks++; if (hi_win != 7) begin errors++; $display("FAIL rd_oe_in_window: got %0d want 7", hi_win); end
        checks++; if (fall != 14) begin errors++; $display("FAIL rd_oe_fall: got edge %0d want 14", fall); end
        checks++; if (dout !== exp_v) begin errors++; $display("FAIL rd_adout: got %h want %h", dout, exp_v); end
        checks++; if (varied != 0) begin errors++; $display("FAIL rd_adout_stable: got %0d changes want 0", varied); end
        checks++; if (cur_addr !== ref_cur) begin errors++; $display("FAIL rd_cur_addr: got %h want %h", cur_addr, ref_cur); end
    endtask

    task automatic test_out_of_range();
        int first, fall, hi, hi_win, varied;
        logic [7:0] dout, exp_v;
        bit exp_st;
        sq_addr.delete(); sq_data.delete();
        bus_write(1'b0, 8'h20);
        m_addr(8'h20);
        bus_write(1'b1, 8'h11);
        m_write(8'h11, exp_st);
        checks++; if (sq_addr.size() != 0) begin errors++; $display("FAIL oor_no_strobe: got %0d want 0", sq_addr.size()); end
        bus_write(1'b0, 8'h20);
        m_addr(8'h20);
        bus_read(5, first, fall, hi, hi_win, dout, varied);
        m_read(exp_v);
        checks++; if (dout !== 8'hFF) begin errors++; $display("FAIL oor_adout: got %h want ff", dout); end
        checks++; if (hi != 5) begin errors++; $display("FAIL oor_oe_cycles: got %0d want 5", hi); end
        host_addr = 8'h20; #1;
        checks++; if (host_data !== 8'hFF) begin errors++; $display("FAIL oor_host: got %h want ff", host_data); end
        for (int i = 0; i < NREGS; i++) begin
            host_addr = 8'(i); #1;
            checks++; if (host_data !== m_host(8'(i))) begin errors++; $display("FAIL oor_regfile[%0d]: got %h want %h", i, host_data, m_host(8'(i))); end
        end
    endtask

    task automatic test_proto();
        int p0, first, fall, hi, hi_win, varied;
        logic [7:0] dout, exp_v;
        p0 = perr_cnt;
        sq_addr.delete(); sq_data.delete();
        @(negedge clk);
        bif.CS = 1'b0; bif.AD = 1'b1; bif.RD = 1'b0; bif.WR = 1'b0; bif.ADin = 8'h42;
        ticks(6);
        bus_idle();
        ticks(6);
        checks++; if (perr_cnt - p0 != 1) begin errors++; $display("FAIL proto_rd_wr_pulses: got %0d want 1", perr_cnt - p0); end
        checks++; if (sq_addr.size() != 0) begin errors++; $display("FAIL proto_no_strobe: got %0d want 0", sq_addr.size()); end
        checks++; if (cur_addr !== ref_cur) begin errors++; $display("FAIL proto_cur_addr: got %h want %h", cur_addr, ref_cur); end
        bus_write(1'b0, 8'h07);
        m_addr(8'h07);
        bus_read(3, first, fall, hi, hi_win, dout, varied);
        m_read(exp_v);
        checks++; if (first != 4) begin errors++; $display("FAIL proto_idle_after: got oe edge %0d want 4", first); end
        checks++; if (dout !== exp_v) begin errors++; $display("FAIL proto_read_after: got %h want %h", dout, exp_v); end
        bus_write(1'b0, 8'h07);
        m_addr(8'h07);
        p0 = perr_cnt;
        @(negedge clk);
        bif.CS = 1'b0; bif.AD = 1'b1; bif.WR = 1'b0; bif.ADin = 8'h77;
        ticks(4);
        bif.CS = 1'b1;
        ticks(3);
        bif.WR = 1'b1;
        ticks(6);
        host_addr = 8'h07; #1;
        checks++; if (sq_addr.size() != 0) begin errors++; $display("FAIL abort_no_strobe: got %0d want 0", sq_addr.size()); end
        checks++; if (host_data !== m_host(8'h07)) begin errors++; $display("FAIL abort_no_commit: got %h want %h", host_data, m_host(8'h07)); end
        checks++; if (perr_cnt != p0) begin errors++; $display("FAIL abort_proto_err: got %0d want %0d", perr_cnt, p0); end
        checks++; if (cur_addr !== ref_cur) begin errors++; $display("FAIL abort_cur_addr: got %h want %h", cur_addr, ref_cur); end
    endtask

`ifdef RTC_RESP_AUTOINC_EN
    task automatic test_autoinc();
        bit exp_st;
        sq_addr.delete(); sq_data.delete();
        bus_write(1'b0, 8'h0F); m_addr(8'h0F);
        bus_write(1'b1, 8'hAA); m_write(8'hAA, exp_st);
        bus_write(1'b1, 8'hBB); m_write(8'hBB, exp_st);
        host_addr = 8'h0F; #1;
        checks++; if (host_data !== 8'hAA) begin errors++; $display("FAIL autoinc_reg15: got %h want aa", host_data); end
        host_addr = 8'h00; #1;
        checks++; if (host_data !== 8'hBB) begin errors++; $display("FAIL autoinc_reg0: got %h want bb", host_data); end
        checks++; if (cur_addr !== 8'h01) begin errors++; $display("FAIL autoinc_cur_addr: got %h want 01", cur_addr); end
        checks++; if (sq_addr.size() != 2) begin errors++; $display("FAIL autoinc_strobes: got %0d want 2", sq_addr.size()); end
        checks++; if (sq_addr[1] !== 8'h00) begin errors++; $display("FAIL autoinc_wrap_addr: got %h want 00", sq_addr[1]); end
    endtask
`endif

    task automatic test_random();
        int op, len, first, fall, hi, hi_win, varied, p0;
        logic [7:0] a, d, dout, exp_v, ea;
        bit exp_st;
        p0 = perr_cnt;
        for (int n = 0; n < 40; n++) begin
            op = $urandom_range(0, 2);
            sq_addr.delete(); sq_data.delete();
            if (op == 0) begin
                a = 8'($urandom_range(0, 19));
                bus_write(1'b0, a);
                m_addr(a);
            end else if (op == 1) begin
                d  = 8'($urandom);
                ea = ref_cur;
                bus_write(1'b1, d);
                m_write(d, exp_st);
                checks++; if (sq_addr.size() != (exp_st ? 1 : 0)) begin errors++; $display("FAIL rnd%0d_strobe_count: got %0d want %0d", n, sq_addr.size(), exp_st ? 1 : 0); end
                if (exp_st && sq_addr.size() == 1) begin
                    checks++; if (sq_addr[0] !== ea || sq_data[0] !== d) begin errors++; $display("FAIL rnd%0d_strobe: got %h/%h want %h/%h", n, sq_addr[0], sq_data[0], ea, d); end
                end
            end else begin
                len = $urandom_range(1, 8);
                bus_read(len, first, fall, hi, hi_win, dout, varied);
                m_read(exp_v);
                checks++; if (dout !== exp_v || varied != 0) begin errors++; $display("FAIL rnd%0d_read: got %h (%0d changes) want %h", n, dout, varied, exp_v); end
                checks++; if (first != 4 || hi != len || fall != len + 4) begin errors++; $display("FAIL rnd%0d_oe_timing: got rise %0d hi %0d fall %0d want 4/%0d/%0d", n, first, hi, fall, len, len + 4); end
            end
            checks++; if (cur_addr !== ref_cur) begin errors++; $display("FAIL rnd%0d_cur_addr: got %h want %h", n, cur_addr, ref_cur); end
            host_addr = 8'($urandom_range(0, 20)); #1;
            checks++; if (host_data !== m_host(host_addr)) begin errors++; $display("FAIL rnd%0d_host[%h]: got %h want %h", n, host_addr, host_data, m_host(host_addr)); end
        end
        checks++; if (perr_cnt != p0) begin errors++; $display("FAIL rnd_proto_err: got %0d want %0d", perr_cnt - p0, 0); end
    endtask

    task automatic test_reset_mid();
        bit exp_st;
        bus_write(1'b0, 8'h03); m_addr(8'h03);
        sq_addr.delete(); sq_data.delete();
        @(negedge clk);
        bif.CS = 1'b0; bif.AD = 1'b1; bif.WR = 1'b0; bif.ADin = 8'h5A;
        ticks(3);
        bif.WR = 1'b1;
        @(posedge clk); #2;
        reset = 1'b1;
        bus_idle();
        ticks(3);
        reset = 1'b0;
        m_reset();
        ticks(6);
        host_addr = 8'h03; #1;
        checks++; if (sq_addr.size() != 0) begin errors++; $display("FAIL rstmid_no_strobe: got %0d want 0", sq_addr.size()); end
        checks++; if (host_data !== 8'h00) begin errors++; $display("FAIL rstmid_no_commit: got %h want 00", host_data); end
        checks++; if (cur_addr !== 8'h00) begin errors++; $display("FAIL rstmid_cur_addr: got %h want 00", cur_addr); end
        bus_write(1'b0, 8'h02); m_addr(8'h02);
        bus_write(1'b1, 8'h99); m_write(8'h99, exp_st);
        bus_write(1'b0, 8'h02); m_addr(8'h02);
        @(negedge clk);
        bif.CS = 1'b0; bif.AD = 1'b1; bif.RD = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checks++; if (bif.data_oe !== 1'b1) begin errors++; $display("FAIL rstmid_oe_before: got %b want 1", bif.data_oe); end
        checks++; if (bif.ADout !== 8'h99) begin errors++; $display("FAIL rstmid_adout_before: got %h want 99", bif.ADout); end
        #1;
        reset = 1'b1;
        #1;
        checks++; if (bif.data_oe !== 1'b0) begin errors++; $display("FAIL rstmid_oe_async: got %b want 0", bif.data_oe); end
        checks++; if (bif.ADout !== 8'h00) begin errors++; $display("FAIL rstmid_adout_async: got %h want 00", bif.ADout); end
        bus_idle();
        ticks(3);
        reset = 1'b0;
        m_reset();
        ticks(4);
        host_addr = 8'h02; #1;
        checks++; if (host_data !== m_host(8'h02)) begin errors++; $display("FAIL rstmid_reg_cleared: got %h want %h", host_data, m_host(8'h02)); end
        checks++; if (bif.data_oe !== 1'b0) begin errors++; $display("FAIL rstmid_oe_after: got %b want 0", bif.data_oe); end
    endtask

    initial begin
        reset = 1'b1;
        bus_idle();
        host_addr = 8'h00;
        test_reset();
        test_write_basic();
        test_read_latency();
        test_out_of_range();
        test_proto();
`ifdef RTC_RESP_AUTOINC_EN
        test_autoinc();
`endif
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
